// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding,
// default parameter values and a small width helper.
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SETUP,
    ST_SEND,
    ST_WAIT_RX,
    ST_HOLD
  } state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_LEN_W       = 4;
  localparam int DEF_CS_GAP      = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Produces a one-hot grant, its index and a hit flag.
module spi_rr_arbiter
  import spi_xfer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // cand[gi] is the requester gi places after the pointer; ptr < NUM_REQ always
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand[gi]     = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                       : sum[IDX_W-1:0];
    assign cand_hit[gi] = req[cand[gi]];
  end

  always_comb begin
    idx = '0;
    any = 1'b0;
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-level SPI master core between NUM_REQ requesters with
// round-robin arbitration. Optional RX watchdog: define SPI_XFER_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
  import spi_xfer_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int CS_GAP      = DEF_CS_GAP,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*LEN_W-1:0] REQ_LEN,
  output logic [NUM_REQ-1:0]       GNT,
  input  logic [NUM_REQ*8-1:0]     TX_DATA,
  input  logic [NUM_REQ-1:0]       TX_VD,
  output logic [NUM_REQ-1:0]       TX_RDY,
  output logic [7:0]               RX_DATA,
  output logic [NUM_REQ-1:0]       RX_VD,
  output logic [NUM_REQ-1:0]       DONE,
  output logic [NUM_REQ-1:0]       CS_N,
  output logic                     BUSY,
  input  logic                     CORE_IN_RDY,
  output logic                     CORE_IN_VD,
  output logic [7:0]               CORE_IN,
  input  logic [7:0]               CORE_OUT,
  input  logic                     CORE_OUT_VD,
  output logic                     ERR
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CS_GAP < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("spi_xfer_arbiter: parameter out of range");
  end

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [NUM_REQ-1:0] cs_n_reg, cs_n_next;
  logic [7:0]         rx_data_reg, rx_data_next;
  logic [NUM_REQ-1:0] rx_vd_reg, rx_vd_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               core_fire;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [7:0]         tx_data_arr [NUM_REQ];
  logic [LEN_W-1:0]   req_len_arr [NUM_REQ];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign tx_data_arr[gi] = TX_DATA[gi*8 +: 8];
    assign req_len_arr[gi] = REQ_LEN[gi*LEN_W +: LEN_W];
  end

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (REQ),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef SPI_XFER_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_reg, to_next;
  logic            err_reg, err_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      to_reg  <= to_next;
      err_reg <= err_next;
    end
  end

  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      gnt_reg     <= '0;
      cnt_reg     <= '0;
      gap_reg     <= '0;
      cs_n_reg    <= '1;
      rx_data_reg <= '0;
      rx_vd_reg   <= '0;
      done_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      gnt_reg     <= gnt_next;
      cnt_reg     <= cnt_next;
      gap_reg     <= gap_next;
      cs_n_reg    <= cs_n_next;
      rx_data_reg <= rx_data_next;
      rx_vd_reg   <= rx_vd_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    gnt_next     = gnt_reg;
    cnt_next     = cnt_reg;
    gap_next     = gap_reg;
    cs_n_next    = cs_n_reg;
    rx_data_next = rx_data_reg;
    rx_vd_next   = '0;
    done_next    = '0;
    core_fire    = 1'b0;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
    to_next      = to_reg;
    err_next     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|REQ) state_next = ST_ARB;
      end
      ST_ARB: begin
        // REQ may have dropped since IDLE; fall back rather than grant nobody
        if (arb_any) begin
          gnt_next   = arb_gnt;
          idx_next   = arb_idx;
          cnt_next   = req_len_arr[arb_idx];
          ptr_next   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cs_n_next  = ~arb_gnt;
          gap_next   = '0;
          state_next = ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (gap_reg == GAP_LAST) begin
          gap_next   = '0;
          state_next = ST_SEND;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      ST_SEND: begin
        if (TX_VD[idx_reg] && CORE_IN_RDY) begin
          core_fire  = 1'b1;
          state_next = ST_WAIT_RX;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
          to_next    = '0;
`endif
        end
      end
      ST_WAIT_RX: begin
        if (CORE_OUT_VD) begin
          rx_data_next = CORE_OUT;
          rx_vd_next   = gnt_reg;
          if (cnt_reg == '0) begin
            gap_next   = '0;
            state_next = ST_HOLD;
          end else begin
            cnt_next   = cnt_reg - 1'b1;
            state_next = ST_SEND;
          end
        end
`ifdef SPI_XFER_ARB_TIMEOUT_EN
        else if (to_reg == TO_LAST) begin
          // abandon the transaction: release CS at once, no DONE
          err_next   = 1'b1;
          cs_n_next  = '1;
          gnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          to_next = to_reg + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (gap_reg == GAP_LAST) begin
          cs_n_next  = '1;
          done_next  = gnt_reg;
          gnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign GNT        = gnt_reg;
  assign CS_N       = cs_n_reg;
  assign BUSY       = (state_reg != ST_IDLE);
  assign RX_DATA    = rx_data_reg;
  assign RX_VD      = rx_vd_reg;
  assign DONE       = done_reg;
  assign CORE_IN_VD = core_fire;
  assign CORE_IN    = core_fire ? tx_data_arr[idx_reg] : 8'h00;
  assign TX_RDY     = core_fire ? gnt_reg : '0;

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares one byte-level SPI master core between NUM_REQ requesters. Each requester asks for a multi-byte transaction.
- Round-robin arbitration selects one requester.
- That requester's active-low chip select is driven for the whole transaction.
- Its TX bytes are sequenced into the core and the core's RX bytes are returned to it.
- Sits between the SPI master core's byte handshake and the client logic.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- LEN_W, 4: width of each requester's length field; bytes per transaction = LEN+1 (1..2^LEN_W).
- CS_GAP, 2: CLK cycles of CS setup before the first byte and hold after the last byte (>=1).
- TIMEOUT_CYC, 1024: RX watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- REQ  in  NUM_REQ  per-requester transaction request (level)
- REQ_LEN  in  NUM_REQ*LEN_W  per-requester length, slice i belongs to requester i
- GNT  out  NUM_REQ  one-hot grant, held for the whole transaction
- TX_DATA  in  NUM_REQ*8  per-requester TX byte
- TX_VD  in  NUM_REQ  per-requester TX byte valid
- TX_RDY  out  NUM_REQ  one-cycle pulse: TX byte consumed
- RX_DATA  out  8  received byte (shared bus)
- RX_VD  out  NUM_REQ  one-cycle pulse to the granted requester
- DONE  out  NUM_REQ  one-cycle pulse: transaction complete
- CS_N  out  NUM_REQ  chip selects, active-low
- BUSY  out  1  high whenever the state is not IDLE
- CORE_IN_RDY  in  1  core can accept a byte
- CORE_IN_VD  out  1  byte valid to core
- CORE_IN  out  8  byte to core
- CORE_OUT  in  8  byte received by core
- CORE_OUT_VD  in  1  core RX byte valid
- ERR  out  1  timeout pulse; tied 0 without the optional feature

Behaviour:
- Reset values:
  - GNT, TX_RDY, RX_VD, DONE, CORE_IN_VD, BUSY, ERR = 0.
  - CS_N = all 1.
  - CORE_IN = 0, RX_DATA = 0.
  - Round-robin pointer = 0.
  - State = IDLE.
- Reset applied mid-transaction returns every output to these values on the next edge. A core byte already in flight is not cancelled; its later CORE_OUT_VD is ignored in IDLE.
- FSM states:
  - IDLE: if any REQ is high, go to ARB.
  - ARB (1 cycle):
    - Pick the first requester with REQ high, searching from the pointer and wrapping modulo NUM_REQ.
    - Set its GNT bit.
    - Latch REQ_LEN into the remaining-byte counter.
    - Pointer = winner+1 (mod NUM_REQ).
    - Drive that requester's CS_N low.
    - Go to SETUP.
  - SETUP: count CS_GAP cycles, then go to SEND.
  - SEND:
    - Wait until granted TX_VD=1 and CORE_IN_RDY=1.
    - In that cycle: CORE_IN = granted TX_DATA, CORE_IN_VD = 1 (exactly one cycle), TX_RDY pulses for the granted requester.
    - Go to WAIT_RX.
    - If TX_VD is low, stall indefinitely with CS held low.
  - WAIT_RX:
    - On CORE_OUT_VD: register RX_DATA = CORE_OUT and pulse RX_VD one cycle later (1-cycle latency).
    - If the counter is 0, go to HOLD; otherwise decrement it and go to SEND.
  - HOLD:
    - Count CS_GAP cycles, then raise CS_N.
    - Pulse DONE for the granted requester.
    - Clear GNT and go to IDLE.
- IDLE always lasts at least 1 cycle, so CS_N stays high for at least 1 cycle between transactions.
- REQ may drop mid-transaction; this is ignored and the transaction runs to its latched length.
- Only one CS_N bit is low at any time. CORE_IN_VD is never asserted outside SEND.
- CORE_OUT_VD seen outside WAIT_RX is dropped.
- Counter width is LEN_W. LEN = 2^LEN_W-1 gives the maximum of 2^LEN_W bytes with no wrap.

Optional Feature:
- Macro: SPI_XFER_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RX.
  - If it reaches TIMEOUT_CYC without CORE_OUT_VD: ERR pulses one cycle, CS_N goes high immediately, GNT clears, no DONE is issued, state goes to IDLE.
  - The counter clears on every WAIT_RX entry.
- Undefined: no counter exists, ERR is constant 0, and WAIT_RX waits indefinitely.

Decomposition:
- Shared package spi_xfer_pkg holds:
  - state encoding constants (IDLE, ARB, SETUP, SEND, WAIT_RX, HOLD);
  - the default widths.
- One sub-module, spi_rr_arbiter: combinational round-robin winner selection from REQ and the pointer, producing a one-hot output plus an index.
- The pointer register stays in the top level.

Test Plan:
- Single requester, NUM_REQ=2, REQ[0]=1, LEN=0, TX_DATA=8'hAA, core returns 8'h55:
  - CS_N[0] is low for CS_GAP+byte+CS_GAP cycles;
  - CORE_IN=AA;
  - RX_DATA=55 with RX_VD[0] pulse;
  - one DONE[0] pulse.
- Multi-byte, LEN=2, bytes 01/02/03:
  - exactly 3 CORE_IN_VD pulses and 3 TX_RDY[0] pulses;
  - CS_N[0] stays low continuously between bytes.
- Contention, REQ=2'b11 from reset:
  - grant order 0,1,0,1 over four transactions;
  - CS_N never has two bits low at once;
  - at least 1 idle cycle with CS_N=2'b11 between transactions.
- TX underflow: TX_VD[1] held low for 20 cycles in SEND:
  - no CORE_IN_VD during the stall and CS_N[1] stays low;
  - transfer resumes when TX_VD rises.
- Reset mid-transaction (RST in WAIT_RX):
  - next cycle CS_N=all 1, GNT=0, BUSY=0;
  - a later stray CORE_OUT_VD produces no RX_VD.
- With SPI_XFER_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, core never responds:
  - ERR pulses 16 cycles after entering WAIT_RX;
  - CS_N goes high and no DONE is issued.
